// File: rtl/ov7670_config_sequencer.sv
// Walks a {reg,value} table and issues one start/write/stop SCCB transaction per entry.
// Handles END/DELAY markers; a per-transaction watchdog aborts the run if the master stalls.
module ov7670_config_sequencer #(
  parameter int ROM_AW         = 8,
  parameter int DELAY_CYCLES   = 1_000_000,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_go,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic              o_start,
  output logic              o_write,
  output logic              o_stop,
  output logic [7:0]        o_addr,
  output logic [7:0]        o_din,
  input  logic              i_ready,
  input  logic              i_done,
  output logic              o_busy,
  output logic              o_config_done,
  output logic              o_error,
  output logic [ROM_AW:0]   o_count
);

  localparam int CW = ROM_AW + 1;
  localparam int DW = $clog2(DELAY_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_XFER, S_STOPW, S_DELAY, S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [7:0]        addr_q, addr_d, din_q, din_d;
  logic              write_q, write_d, stop_q, stop_d;
  logic              busy_q, busy_d, cfg_done_q, cfg_done_d, error_q, error_d;
  logic              go_pend_q, go_pend_d;
  logic [1:0]        tick_q, tick_d;
  logic [WW-1:0]     wd_q, wd_d;
  logic [DW-1:0]     dly_q, dly_d;

  logic is_end, is_delay, last_entry, start_fire, third_done, wd_run, wd_expire, go_req;

  assign is_end     = (i_rom_data == 16'hFFFF);
  assign is_delay   = (i_rom_data == 16'hFFF0);
  assign last_entry = &rom_addr_q;
  assign start_fire = (state_q == S_ISSUE) && i_ready;
  assign third_done = (state_q == S_XFER) && i_done && (tick_q == 2'd2);
  assign wd_run     = (state_q == S_XFER) || (state_q == S_STOPW);
  // wd_q holds cycles elapsed since o_start / the last i_done; a same-cycle i_done wins
  assign wd_expire  = wd_run && !i_done && (wd_q == WW'(TIMEOUT_CYCLES - 1));
  assign go_req     = i_go || go_pend_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      write_q    <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
      cfg_done_q <= 1'b0;
      error_q    <= 1'b0;
      go_pend_q  <= 1'b0;
      tick_q     <= '0;
      wd_q       <= '0;
      dly_q      <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      write_q    <= write_d;
      stop_q     <= stop_d;
      busy_q     <= busy_d;
      cfg_done_q <= cfg_done_d;
      error_q    <= error_d;
      go_pend_q  <= go_pend_d;
      tick_q     <= tick_d;
      wd_q       <= wd_d;
      dly_q      <= dly_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (go_req) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (is_end)        state_d = S_FINISH;
        else if (is_delay) state_d = S_DELAY;
        else               state_d = S_ISSUE;
      end
      S_ISSUE:  if (i_ready) state_d = S_XFER;
      S_XFER: begin
        if (third_done)     state_d = S_STOPW;
        else if (wd_expire) state_d = S_IDLE;
      end
      S_STOPW: begin
        if (i_ready)        state_d = last_entry ? S_FINISH : S_FETCH;
        else if (wd_expire) state_d = S_IDLE;
      end
      S_DELAY:  if (dly_q == '0) state_d = last_entry ? S_FINISH : S_FETCH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rom_addr_d = rom_addr_q;
    count_d    = count_q;
    addr_d     = addr_q;
    din_d      = din_q;
    write_d    = write_q;
    stop_d     = stop_q;
    busy_d     = busy_q;
    cfg_done_d = cfg_done_q;
    error_d    = error_q;
    go_pend_d  = 1'b0;
    tick_d     = tick_q;
    wd_d       = wd_q;
    dly_d      = dly_q;
    unique case (state_q)
      S_IDLE: begin
        if (go_req) begin
          rom_addr_d = '0;
          count_d    = '0;
          cfg_done_d = 1'b0;
          error_d    = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_delay) begin
          dly_d = DW'(DELAY_CYCLES - 1);
        end else if (!is_end) begin
          addr_d = i_rom_data[15:8];
          din_d  = i_rom_data[7:0];
        end
      end
      S_ISSUE: begin
        if (i_ready) begin
          write_d = 1'b1;
          tick_d  = '0;
          wd_d    = WW'(1);
        end
      end
      S_XFER: begin
        if (i_done) begin
          tick_d = tick_q + 2'd1;
          wd_d   = WW'(1);
        end else begin
          wd_d = wd_q + WW'(1);
        end
        if (third_done) begin
          write_d = 1'b0;
          stop_d  = 1'b1;
        end else if (wd_expire) begin
          write_d = 1'b0;
          stop_d  = 1'b0;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_STOPW: begin
        wd_d = wd_q + WW'(1);
        if (i_ready) begin
          stop_d  = 1'b0;
          count_d = count_q + CW'(1);
          if (!last_entry) rom_addr_d = rom_addr_q + ROM_AW'(1);
        end else if (wd_expire) begin
          write_d = 1'b0;
          stop_d  = 1'b0;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_DELAY: begin
        if (dly_q == '0) begin
          if (!last_entry) rom_addr_d = rom_addr_q + ROM_AW'(1);
        end else begin
          dly_d = dly_q - DW'(1);
        end
      end
      S_FINISH: begin
        cfg_done_d = 1'b1;
        busy_d     = 1'b0;
        go_pend_d  = i_go;
      end
      default: ;
    endcase
  end

  // o_start is Mealy on i_ready so the write begins the same cycle the master is seen idle
  assign o_start       = start_fire;
  assign o_write       = write_q | start_fire;
  assign o_stop        = stop_q;
  assign o_addr        = addr_q;
  assign o_din         = din_q;
  assign o_rom_addr    = rom_addr_q;
  assign o_busy        = busy_q;
  assign o_config_done = cfg_done_q;
  assign o_error       = error_q;
  assign o_count       = count_q;

endmodule

// File: doc/ov7670_config_sequencer.md
Name: ov7670_config_sequencer

Overview:
- Walks a table of OV7670 register/value pairs and drives the SCCB master's command interface, one 3-phase write per entry.
- Sits directly upstream of the SCCB master: it issues start, write and stop, and consumes the master's ready and done.
- Supports end-of-table and delay marker entries.
- Reports busy, completion, entry count and a per-transaction watchdog error.

Parameters:
- ROM_AW, 8: table address width; up to 256 entries.
- DELAY_CYCLES, 1_000_000: clock cycles waited for a delay marker (10 ms at 100 MHz).
- TIMEOUT_CYCLES, 200_000: maximum cycles between o_start and each i_done, and from the 3rd i_done to i_ready.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_go  in  1  1-cycle request to run the table from entry 0
- o_rom_addr  out  ROM_AW  table address
- i_rom_data  in  16  {reg_addr[15:8], value[7:0]}; valid exactly 1 cycle after o_rom_addr changes
- o_start  out  1  1-cycle start pulse to the SCCB master
- o_write  out  1  write command, held for the whole transaction
- o_stop  out  1  stop request after the final byte
- o_addr  out  8  register address to the master
- o_din  out  8  register value to the master
- i_ready  in  1  master idle
- i_done  in  1  master per-byte completion tick
- o_busy  out  1  sequence in progress
- o_config_done  out  1  table completed; level output
- o_error  out  1  watchdog expired; level output
- o_count  out  ROM_AW+1  number of entries written

Behaviour:
- Reset (async, i_rst=1): state IDLE; all outputs 0.
- Table markers: entry 16'hFFFF = END; entry 16'hFFF0 = DELAY; any other value = WRITE.
- IDLE:
  - o_busy=0.
  - On i_go: o_rom_addr=0, o_count=0, clear o_config_done and o_error, o_busy=1, go to FETCH.
- FETCH: one cycle for ROM latency, then DECODE.
- DECODE:
  - END: go to FINISH.
  - DELAY: load delay counter, go to DELAY.
  - WRITE: latch o_addr=data[15:8], o_din=data[7:0], go to ISSUE.
- ISSUE:
  - Wait for i_ready=1.
  - Then o_start=1 and o_write=1 in the same cycle; o_start lasts exactly 1 cycle. Go to XFER.
- XFER:
  - o_write held high; count i_done ticks (2-bit counter).
  - On the 3rd tick: o_write<=0, o_stop<=1, go to STOPW.
- STOPW:
  - Wait for i_ready=1, then o_stop<=0 and o_count+=1.
  - If o_rom_addr == 2^ROM_AW-1, go to FINISH (no wrap). Otherwise o_rom_addr+=1 and go to FETCH.
- DELAY:
  - Count DELAY_CYCLES; on expiry advance o_rom_addr exactly as in STOPW, without incrementing o_count.
  - Delay markers do not touch the SCCB command outputs.
- FINISH: o_config_done=1, o_busy=0, return to IDLE. o_config_done holds until the next i_go.
- Watchdog:
  - Counter clears on o_start and on each i_done; counts in XFER and STOPW.
  - On reaching TIMEOUT_CYCLES: o_write=0, o_stop=0, o_error=1, o_busy=0, go to IDLE.
  - o_error holds until the next i_go.
- Simultaneous events:
  - i_go while o_busy=1 is ignored.
  - i_done in the same cycle as the watchdog expiring: i_done wins and the counter clears.
  - i_go in the same cycle as FINISH: restarts after the IDLE cycle.
- Reset mid-transaction drops o_write, o_stop and o_start immediately. The master must be reset alongside the sequencer.
- Latency, normal entry: i_go→o_rom_addr=0 is 1 cycle; FETCH→o_start is 2 cycles when i_ready=1.

Test Plan:
- Table {1280, FFFF} with a master model (3 i_done ticks, ready back 20 cycles after the 3rd) → single o_start; o_addr=0x12, o_din=0x80; o_write high until the 3rd i_done; o_stop high until i_ready; o_count=1; o_config_done=1.
- Table {1280, FFF0, 1104, FFFF}, DELAY_CYCLES=50 → second o_start occurs ≥50 cycles after the first transaction's stop completes; o_count=2; o_addr=0x11, o_din=0x04 on the second write.
- Table with i_done never asserted, TIMEOUT_CYCLES=100 → o_error=1 exactly 100 cycles after o_start; o_write=0; o_busy=0; o_config_done=0.
- ROM_AW=2, four WRITE entries and no END marker → exactly 4 transactions; o_count=4; o_config_done=1; o_rom_addr stays 3 (no wrap).
- i_go pulsed during XFER → no restart and o_count unaffected; i_go after completion → o_config_done clears and the table re-runs from address 0.
- i_rst asserted in XFER → same cycle (async): o_write=0, o_busy=0, o_count=0; next i_go restarts from entry 0.
